// File: rtl/decoder_prog_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// decoder_prog_ctrl_pkg
//   Shared definitions for the 256-bit pattern decoder sequencer:
//   - controller state encoding (also visible on the state_dbg port)
//   - default geometry of the decoder and host word interface
//   - helpers for sizing counters and checking the pattern geometry
// -----------------------------------------------------------------------------
package decoder_prog_ctrl_pkg;

   // Controller states. The 2-bit encoding is exported on state_dbg.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_ARMED = 2'd3
   } ctrl_state_e;

   // Default geometry: decoder width, host word width, match counter width.
   localparam int unsigned DEF_PAT_LEN = 256;
   localparam int unsigned DEF_WORD_W  = 8;
   localparam int unsigned DEF_CNT_W   = 16;

   // Width of a counter that must hold values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val <= 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

   // The pattern must be an exact, non-empty whole number of host words.
   function automatic bit pat_geometry_ok(input int unsigned pat_len,
                                          input int unsigned word_w);
      return (word_w > 0) && (pat_len >= word_w) && ((pat_len % word_w) == 0);
   endfunction

endpackage

// File: rtl/decoder_prog_ctrl_pat_serializer.sv
// -----------------------------------------------------------------------------
// decoder_prog_ctrl_pat_serializer
//   WORD_W-bit load/shift register that turns host pattern words into a
//   serial bit stream, LSB first, one bit per clock.
//
//   Handshake: a word transfers on a rising edge where pat_valid and
//   pat_ready are both high; the host holds pat_data stable while pat_valid
//   is high and pat_ready is low. pat_ready never depends on pat_valid.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset (empties the shifter)
//   flush      in   synchronous: discard any partially shifted word
//   accept_en  in   the controller will take another word this cycle
//   pat_valid  in   host word valid
//   pat_data   in   host word, shifted out LSB first
//   pat_ready  out  word accepted this cycle if pat_valid is high
//   bit_out    out  current serial bit
//   bit_valid  out  bit_out holds a pattern bit this cycle
//   last_bit   out  bit_out is the final bit of the current word
// -----------------------------------------------------------------------------
module decoder_prog_ctrl_pat_serializer
   import decoder_prog_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W
)
(
   input  logic              clk,
   input  logic              clr,
   input  logic              flush,
   input  logic              accept_en,
   input  logic              pat_valid,
   input  logic [WORD_W-1:0] pat_data,
   output logic              pat_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              last_bit
);

   localparam int unsigned CW = cnt_width(WORD_W);

   logic [WORD_W-1:0] shreg_q;
   logic [CW-1:0]     left_q;   // pattern bits still to be shifted out
   logic              take;

   assign bit_valid = (left_q != '0);
   assign last_bit  = (left_q == CW'(1));
   assign bit_out   = shreg_q[0];

   // Ready while empty, and also while the final bit is on the line so the
   // next word lands in the very next cycle with no gap in the stream.
   assign pat_ready = accept_en && (!bit_valid || last_bit);
   assign take      = pat_valid && pat_ready;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         shreg_q <= '0;
         left_q  <= '0;
      end else if (flush) begin
         shreg_q <= '0;
         left_q  <= '0;
      end else if (take) begin
         shreg_q <= pat_data;
         left_q  <= CW'(WORD_W);
      end else if (bit_valid) begin
         shreg_q <= shreg_q >> 1;
         left_q  <= left_q - CW'(1);
      end
   end

endmodule

// File: rtl/decoder_prog_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_prog_ctrl
//   Sequencer for the 256-bit pattern decoder. Clears the decoder, streams a
//   pattern received as host words onto dec_prgm/dec_enable, then arms the
//   decoder, counts match cycles and raises a sticky interrupt.
//
//   Handshake: a pattern word transfers on a rising edge where pat_valid and
//   pat_ready are both high; pat_data is held while pat_valid is high and
//   pat_ready is low. pat_ready does not depend on pat_valid.
//
// Ports
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-low reset
//   start        in   1-cycle request: (re)program the decoder
//   abort        in   1-cycle request: back to IDLE, clear the decoder
//   pat_valid    in   host pattern word valid
//   pat_data     in   host pattern word (WORD_W), LSB shifted first
//   pat_ready    out  pattern word accepted this cycle
//   dec_clr      out  active-high clear to decoder registers
//   dec_enable   out  shift enable for the decoder PROGRAM register
//   dec_prgm     out  serial pattern bit
//   dec_match    in   decoder equality output
//   armed        out  pattern loaded, matches being counted
//   busy         out  CLEAR or LOAD in progress
//   match_pulse  out  dec_match registered while armed
//   match_count  out  saturating count of armed match cycles (CNT_W)
//   irq          out  sticky match interrupt
//   irq_ack      in   clears irq (a same-cycle match keeps it set)
//   state_dbg    out  current controller state (ctrl_state_e encoding)
// -----------------------------------------------------------------------------
module decoder_prog_ctrl
   import decoder_prog_ctrl_pkg::*;
#(
   parameter int unsigned PAT_LEN = DEF_PAT_LEN,
   parameter int unsigned WORD_W  = DEF_WORD_W,
   parameter int unsigned CNT_W   = DEF_CNT_W
)
(
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              abort,
   input  logic              pat_valid,
   input  logic [WORD_W-1:0] pat_data,
   output logic              pat_ready,
   output logic              dec_clr,
   output logic              dec_enable,
   output logic              dec_prgm,
   input  logic              dec_match,
   output logic              armed,
   output logic              busy,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_count,
   output logic              irq,
   input  logic              irq_ack,
   output logic [1:0]        state_dbg
);

   localparam int unsigned N_WORDS    = PAT_LEN / WORD_W;
   localparam int unsigned BIT_CW     = cnt_width(PAT_LEN);
   localparam int unsigned WORD_CNT_W = cnt_width(N_WORDS);

   if (!pat_geometry_ok(PAT_LEN, WORD_W)) begin : g_bad_geometry
      $error("decoder_prog_ctrl: PAT_LEN must be a non-zero multiple of WORD_W");
   end

   ctrl_state_e state_q, state_d;

   logic [BIT_CW-1:0]     bit_cnt_q;    // pattern bits already enabled
   logic [WORD_CNT_W-1:0] word_cnt_q;   // host words already accepted
   logic [CNT_W-1:0]      match_cnt_q;
   logic                  irq_q;
   logic                  match_pulse_q;
   logic                  abort_clr_q;  // dec_clr pulse in the cycle after an abort

   logic in_idle, in_clear, in_load, in_armed;
   logic ser_bit, ser_bit_valid, ser_last_bit;
   logic ser_flush, accept_en, word_take;
   logic last_pat_bit, count_en, cnt_sat;

   assign in_idle  = (state_q == ST_IDLE);
   assign in_clear = (state_q == ST_CLEAR);
   assign in_load  = (state_q == ST_LOAD);
   assign in_armed = (state_q == ST_ARMED);

   // ---------------------------------------------------------------------------
   // Word intake and serialisation
   // ---------------------------------------------------------------------------
   // Stop accepting once the whole pattern is in, and never accept on an abort
   // cycle since that word would be discarded.
   assign accept_en = in_load && !abort && (word_cnt_q < WORD_CNT_W'(N_WORDS));
   assign ser_flush = in_clear || abort;
   assign word_take = pat_valid && pat_ready;

   decoder_prog_ctrl_pat_serializer #(
      .WORD_W (WORD_W)
   ) u_pat_serializer (
      .clk       (clk),
      .clr       (clr),
      .flush     (ser_flush),
      .accept_en (accept_en),
      .pat_valid (pat_valid),
      .pat_data  (pat_data),
      .pat_ready (pat_ready),
      .bit_out   (ser_bit),
      .bit_valid (ser_bit_valid),
      .last_bit  (ser_last_bit)
   );

   assign dec_enable = in_load && ser_bit_valid;
   assign dec_prgm   = dec_enable && ser_bit;

   // The final pattern bit is always the final bit of the final word.
   assign last_pat_bit = dec_enable && ser_last_bit &&
                         (bit_cnt_q == BIT_CW'(PAT_LEN - 1));

   // ---------------------------------------------------------------------------
   // Controller FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // abort is checked first in every state so it wins over start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (last_pat_bit) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_CLEAR;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign state_dbg = state_q;

   // ---------------------------------------------------------------------------
   // Load progress counters: zeroed by CLEAR, advanced only in LOAD. After an
   // abort they keep stale values, which is harmless as CLEAR precedes LOAD.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else if (in_clear) begin
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else if (in_load) begin
         if (dec_enable) begin
            bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
         end
         if (word_take) begin
            word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Match counting and interrupt
   // ---------------------------------------------------------------------------
   assign count_en = in_armed && dec_match;
   assign cnt_sat  = &match_cnt_q;

   // The count is left untouched in IDLE so software can read it after abort.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         match_cnt_q <= '0;
      end else if (in_clear) begin
         match_cnt_q <= '0;
      end else if (count_en && !cnt_sat) begin
         match_cnt_q <= match_cnt_q + CNT_W'(1);
      end
   end

   // A match in the same cycle as irq_ack keeps the interrupt asserted.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         irq_q <= 1'b0;
      end else if (in_clear) begin
         irq_q <= 1'b0;
      end else if (count_en) begin
         irq_q <= 1'b1;
      end else if (irq_ack) begin
         irq_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         match_pulse_q <= 1'b0;
         abort_clr_q   <= 1'b0;
      end else begin
         match_pulse_q <= count_en;
         abort_clr_q   <= abort && !in_idle;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. dec_clr follows clr directly so the decoder is held clear for
   // the whole reset, not just from the first clock edge.
   // ---------------------------------------------------------------------------
   assign dec_clr     = !clr || in_clear || abort_clr_q;
   assign armed       = in_armed;
   assign busy        = in_clear || in_load;
   assign match_pulse = match_pulse_q;
   assign match_count = match_cnt_q;
   assign irq         = irq_q;

endmodule
